// File: rtl/test_cond_bist_if.sv
// Bus between the BIST sequencer and its host/condition-unit environment.
// The slave side is the sequencer; the master side drives the host inputs and cu_y.
interface test_cond_bist_if;
    logic        start;
    logic [4:0]  num_vec;
    logic        vec_we;
    logic [3:0]  vec_addr;
    logic [0:31] vec_a;
    logic [0:2]  vec_op;
    logic        vec_exp;
    logic [0:31] cu_a;
    logic [0:2]  cu_op;
    logic        cu_y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  fail_cnt;
    logic        first_fail_valid;
    logic [3:0]  first_fail_idx;
    logic [1:0]  state;

    modport slave (
        input  start, num_vec, vec_we, vec_addr, vec_a, vec_op, vec_exp, cu_y,
        output cu_a, cu_op, busy, done, pass, fail_cnt, first_fail_valid,
               first_fail_idx, state
    );

    modport master (
        output start, num_vec, vec_we, vec_addr, vec_a, vec_op, vec_exp, cu_y,
        input  cu_a, cu_op, busy, done, pass, fail_cnt, first_fail_valid,
               first_fail_idx, state
    );
endinterface

// File: rtl/test_cond_bist.sv
// Self-test sequencer: replays a loadable vector table into the condition unit,
// compares cu_y against the expected bit and reports pass / fail count / first failure.
module test_cond_bist #(
    parameter int SETTLE_CYCLES = 0,
    parameter int VEC_DEPTH     = 16
) (
    input  logic             clk,
    input  logic             rst,
    test_cond_bist_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] SETTLE = 3'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  last_q, last_d;
    logic [2:0]  wait_q, wait_d;
    logic [4:0]  fail_cnt_q, fail_cnt_d;
    logic        ffv_q, ffv_d;
    logic [3:0]  ffi_q, ffi_d;
    logic        pass_q, pass_d;
    logic [0:31] cu_a_q, cu_a_d;
    logic [0:2]  cu_op_q, cu_op_d;

    logic [0:31]          tab_a_q  [VEC_DEPTH];
    logic [0:2]           tab_op_q [VEC_DEPTH];
    logic [VEC_DEPTH-1:0] tab_exp_q;

    logic       tab_we;
    logic       wr_hits_0;
    logic [3:0] idx_inc;
    logic [4:0] nv_clamp;
    logic       mismatch;
    logic [4:0] fc_next;

    // start is a single-cycle request with no ready: it is accepted only when
    // the sequencer is IDLE, and silently dropped otherwise (never queued).
    assign tab_we    = (state_q == IDLE) && bus.vec_we;
    assign wr_hits_0 = tab_we && (bus.vec_addr == 4'd0);
    assign idx_inc   = idx_q + 4'd1;
    assign nv_clamp  = (bus.num_vec > 5'd16) ? 5'd16 : bus.num_vec;

    always_ff @(posedge clk) begin
        if (!rst && tab_we) begin
            tab_a_q[bus.vec_addr]   <= bus.vec_a;
            tab_op_q[bus.vec_addr]  <= bus.vec_op;
            tab_exp_q[bus.vec_addr] <= bus.vec_exp;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        wait_d     = wait_q;
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        ffi_d      = ffi_q;
        pass_d     = pass_q;
        cu_a_d     = cu_a_q;
        cu_op_d    = cu_op_q;
        mismatch   = 1'b0;
        fc_next    = fail_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    fail_cnt_d = 5'd0;
                    ffv_d      = 1'b0;
                    if (bus.num_vec == 5'd0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        pass_d  = 1'b0;
                        idx_d   = 4'd0;
                        last_d  = 4'(nv_clamp - 5'd1);
                        wait_d  = SETTLE;
                        // A same-cycle write to entry 0 must be visible to this run.
                        cu_a_d  = wr_hits_0 ? bus.vec_a  : tab_a_q[0];
                        cu_op_d = wr_hits_0 ? bus.vec_op : tab_op_q[0];
                    end
                end
            end
            RUN: begin
                if (wait_q != 3'd0) begin
                    wait_d = wait_q - 3'd1;
                end else begin
                    mismatch   = bus.cu_y != tab_exp_q[idx_q];
                    fc_next    = fail_cnt_q + {4'd0, mismatch};
                    fail_cnt_d = fc_next;
                    if (mismatch && !ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                    if (idx_q == last_q) begin
                        state_d = DONE;
                        pass_d  = (fc_next == 5'd0);
                    end else begin
                        idx_d   = idx_inc;
                        cu_a_d  = tab_a_q[idx_inc];
                        cu_op_d = tab_op_q[idx_inc];
                        wait_d  = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            last_q     <= 4'd0;
            wait_q     <= 3'd0;
            fail_cnt_q <= 5'd0;
            ffv_q      <= 1'b0;
            ffi_q      <= 4'd0;
            pass_q     <= 1'b0;
            cu_a_q     <= '0;
            cu_op_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            fail_cnt_q <= fail_cnt_d;
            ffv_q      <= ffv_d;
            ffi_q      <= ffi_d;
            pass_q     <= pass_d;
            cu_a_q     <= cu_a_d;
            cu_op_q    <= cu_op_d;
        end
    end

    assign bus.cu_a             = cu_a_q;
    assign bus.cu_op            = cu_op_q;
    assign bus.busy             = (state_q != IDLE);
    assign bus.done             = (state_q == DONE);
    assign bus.pass             = pass_q;
    assign bus.fail_cnt         = fail_cnt_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_idx   = ffi_q;
    assign bus.state            = state_q;
endmodule

// File: tb/tb_test_cond_bist.sv
// Bench for test_cond_bist: two instances (settle 0 and settle 2) share one stimulus
// stream, each closed around its own model condition unit.
module tb_test_cond_bist;
  logic clk;
  logic rst;

  logic        start;
  logic [4:0]  num_vec;
  logic        vec_we;
  logic [3:0]  vec_addr;
  logic [0:31] vec_a;
  logic [0:2]  vec_op;
  logic        vec_exp;

  int n_cmp;
  int n_fail;

  logic [18:0] exp_q[$];

  typedef struct {
    logic [4:0] nv;
    logic [3:0] exp_mask;
    logic       flip15;
    logic       exp_pass;
    logic [4:0] exp_fc;
    logic       exp_ffv;
    logic [3:0] exp_ffi;
    int         exp_cycles;
  } rec_t;

  rec_t        recs[8];
  logic [0:31] base_a[4];
  logic [0:2]  base_op[4];

  test_cond_bist_if bif0();
  test_cond_bist_if bif2();

  // Reference condition unit: 0 eq0, 1 ne0, 2 lt0, 3 gt0, 4 ge0, 5 le0, 6 true, 7 false.
  function automatic logic cond_model(input logic [0:31] a, input logic [0:2] op);
    logic z;
    logic n;
    z = (a == 32'd0);
    n = a[0];
    case (op)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n;
      3'd3: return !n && !z;
      3'd4: return !n;
      3'd5: return n || z;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign bif0.start    = start;
  assign bif0.num_vec  = num_vec;
  assign bif0.vec_we   = vec_we;
  assign bif0.vec_addr = vec_addr;
  assign bif0.vec_a    = vec_a;
  assign bif0.vec_op   = vec_op;
  assign bif0.vec_exp  = vec_exp;
  assign bif0.cu_y     = cond_model(bif0.cu_a, bif0.cu_op);

  assign bif2.start    = start;
  assign bif2.num_vec  = num_vec;
  assign bif2.vec_we   = vec_we;
  assign bif2.vec_addr = vec_addr;
  assign bif2.vec_a    = vec_a;
  assign bif2.vec_op   = vec_op;
  assign bif2.vec_exp  = vec_exp;
  assign bif2.cu_y     = cond_model(bif2.cu_a, bif2.cu_op);

  test_cond_bist #(.SETTLE_CYCLES(0), .VEC_DEPTH(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bif0.slave)
  );

  test_cond_bist #(.SETTLE_CYCLES(2), .VEC_DEPTH(16)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bif2.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // driver tasks: called just after a negedge, return just after a later negedge
  task automatic write_vec(input logic [3:0] addr, input logic [0:31] a,
                           input logic [0:2] op, input logic e);
    vec_we   = 1'b1;
    vec_addr = addr;
    vec_a    = a;
    vec_op   = op;
    vec_exp  = e;
    @(negedge clk);
    vec_we   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bif0.busy || bif2.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("wait_idle");
  endtask

  // mode 0: plain run; 1: start/vec_we pulsed while busy; 2: write entry 0 with start
  task automatic run_and_score(input logic [4:0] nv, input logic [18:0] expv, input int mode);
    int          cyc;
    logic [18:0] e;
    exp_q.push_back(expv);
    if (mode == 2) begin
      vec_we   = 1'b1;
      vec_addr = 4'd0;
      vec_a    = 32'd5;
      vec_op   = 3'd0;
      vec_exp  = 1'b0;
    end
    start   = 1'b1;
    num_vec = nv;
    @(negedge clk);
    start  = 1'b0;
    vec_we = 1'b0;
    if (mode == 1) begin
      start    = 1'b1;
      num_vec  = 5'd1;
      vec_we   = 1'b1;
      vec_addr = 4'd0;
      vec_a    = 32'd7;
      vec_op   = 3'd0;
      vec_exp  = 1'b1;
    end
    cyc = 0;
    while (!bif0.done && cyc < 200) begin
      @(negedge clk);
      start  = 1'b0;
      vec_we = 1'b0;
      cyc++;
    end
    if (cyc >= 200) timeout("wait_done");
    e = exp_q.pop_front();
    check("done_cycles", 64'(cyc), 64'(e[18:11]));
    check("pass", 64'(bif0.pass), 64'(e[10]));
    check("fail_cnt", 64'(bif0.fail_cnt), 64'(e[9:5]));
    check("first_fail_valid", 64'(bif0.first_fail_valid), 64'(e[4]));
    if (e[4]) check("first_fail_idx", 64'(bif0.first_fail_idx), 64'(e[3:0]));
    @(negedge clk);
    check("after_done", 64'({bif0.done, bif0.busy, bif0.pass}), 64'({2'b00, e[10]}));
  endtask

  function automatic logic [18:0] pack_exp(input int cyc, input logic p, input logic [4:0] fc,
                                           input logic ffv, input logic [3:0] ffi);
    return {8'(cyc), p, fc, ffv, ffi};
  endfunction

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    num_vec  = 5'd0;
    vec_we   = 1'b0;
    vec_addr = 4'd0;
    vec_a    = '0;
    vec_op   = '0;
    vec_exp  = 1'b0;

    base_a[0] = 32'd0;  base_op[0] = 3'd0;
    base_a[1] = 32'd0;  base_op[1] = 3'd1;
    base_a[2] = 32'd1;  base_op[2] = 3'd1;
    base_a[3] = 32'd0;  base_op[3] = 3'd4;

    // mask bit i = expected y of entry i; 4'b1101 is the correct set for the base vectors
    recs[0] = '{5'd4,  4'b1101, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0,  4};
    recs[1] = '{5'd4,  4'b1001, 1'b0, 1'b0, 5'd1, 1'b1, 4'd2,  4};
    recs[2] = '{5'd4,  4'b0010, 1'b0, 1'b0, 5'd4, 1'b1, 4'd0,  4};
    recs[3] = '{5'd2,  4'b1111, 1'b0, 1'b0, 5'd1, 1'b1, 4'd1,  2};
    recs[4] = '{5'd20, 4'b1101, 1'b1, 1'b0, 5'd1, 1'b1, 4'd15, 16};
    recs[5] = '{5'd15, 4'b1101, 1'b1, 1'b1, 5'd0, 1'b0, 4'd0,  15};
    recs[6] = '{5'd16, 4'b0101, 1'b0, 1'b0, 5'd1, 1'b1, 4'd3,  16};
    recs[7] = '{5'd0,  4'b1101, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0,  0};

    repeat (3) @(negedge clk);
    // a start and write held during reset must be overridden
    start   = 1'b1;
    num_vec = 5'd4;
    vec_we  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    vec_we = 1'b0;
    rst    = 1'b0;
    check("reset_ctrl0", 64'({bif0.busy, bif0.done, bif0.pass, bif0.fail_cnt,
                              bif0.first_fail_valid, bif0.first_fail_idx, bif0.state}), 64'd0);
    check("reset_cu0", 64'({bif0.cu_a, bif0.cu_op}), 64'd0);
    check("reset_ctrl2", 64'({bif2.busy, bif2.done, bif2.pass, bif2.fail_cnt,
                              bif2.first_fail_valid, bif2.first_fail_idx, bif2.state}), 64'd0);

    for (int i = 4; i < 15; i++) write_vec(4'(i), 32'(i * 3 + 1), 3'd1, 1'b1);

    // table-driven runs
    for (int r = 0; r < 8; r++) begin
      wait_idle();
      for (int i = 0; i < 4; i++) write_vec(4'(i), base_a[i], base_op[i], recs[r].exp_mask[i]);
      write_vec(4'd15, 32'd46, 3'd1, !recs[r].flip15);
      run_and_score(recs[r].nv,
                    pack_exp(recs[r].exp_cycles, recs[r].exp_pass, recs[r].exp_fc,
                             recs[r].exp_ffv, recs[r].exp_ffi), 0);
    end

    // settle = 2: each vector held 3 cycles, done after edge 9
    wait_idle();
    for (int i = 0; i < 4; i++) write_vec(4'(i), base_a[i], base_op[i], i != 1);
    start   = 1'b1;
    num_vec = 5'd3;
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < 9; e++) begin
      check("settle_cu", 64'({bif2.cu_a, bif2.cu_op}),
            64'({base_a[e / 3], base_op[e / 3]}));
      check("settle_not_done", 64'(bif2.done), 64'd0);
      @(negedge clk);
    end
    check("settle_done", 64'({bif2.done, bif2.pass, bif2.fail_cnt}), 64'({2'b11, 5'd0}));

    // reset in the middle of a run
    wait_idle();
    start   = 1'b1;
    num_vec = 5'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ctrl", 64'({bif0.busy, bif0.done, bif0.pass, bif0.fail_cnt,
                              bif0.first_fail_valid, bif0.first_fail_idx, bif0.state}), 64'd0);
    check("midrst_cu_a", 64'(bif0.cu_a), 64'd0);
    check("midrst_cu_op", 64'(bif0.cu_op), 64'd0);
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
        saw_done |= bif0.done;
        @(negedge clk);
      end
      check("midrst_no_done", 64'(saw_done), 64'd0);
    end
    run_and_score(5'd4, pack_exp(4, 1'b1, 5'd0, 1'b0, 4'd0), 0);

    // start and write while busy are dropped
    wait_idle();
    run_and_score(5'd4, pack_exp(4, 1'b1, 5'd0, 1'b0, 4'd0), 1);
    begin
      logic saw_busy;
      saw_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        saw_busy |= bif0.busy;
        @(negedge clk);
      end
      check("no_second_run", 64'(saw_busy), 64'd0);
    end
    wait_idle();
    run_and_score(5'd4, pack_exp(4, 1'b1, 5'd0, 1'b0, 4'd0), 0);

    // write to entry 0 in the same cycle as start
    wait_idle();
    run_and_score(5'd4, pack_exp(4, 1'b1, 5'd0, 1'b0, 4'd0), 2);
    check("cu_a_after_wr_start", 64'(bif0.cu_a), 64'd0);
    wait_idle();
    write_vec(4'd0, 32'd5, 3'd0, 1'b1);
    run_and_score(5'd1, pack_exp(1, 1'b0, 5'd1, 1'b1, 4'd0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
